// File: rtl/mem_wait_ram.sv
// RV32I data memory with a fixed programmable access latency behind a valid/ready request channel.
// Stores commit and loads are sampled on the edge that enters RESP; the response strobe lasts one cycle.
module mem_wait_ram #(
    parameter int ADDR_WIDTH  = 32,
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [2:0]            req_funct3,
    input  logic [31:0]           req_wdata,
    output logic                  rsp_valid,
    output logic [31:0]           rsp_rdata,
    output logic                  rsp_err
);
    localparam int IDX_W = $clog2(DEPTH_WORDS);

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t state, state_nxt;
    logic [3:0] cnt, cnt_nxt;
    logic       in_idle, accept, commit;

    logic                  lat_we;
    logic [ADDR_WIDTH-1:0] lat_addr;
    logic [2:0]            lat_funct3;
    logic [31:0]           lat_wdata;

    logic                  cur_we;
    logic [ADDR_WIDTH-1:0] cur_addr;
    logic [2:0]            cur_funct3;
    logic [31:0]           cur_wdata;

    logic [IDX_W-1:0] word_idx;
    logic [1:0]       lane;
    logic             bad_funct3, misaligned, out_of_range, acc_err;
    logic [3:0]       be;
    logic [31:0]      wlane, rword, rshift, load_val, rdata_nxt;
    logic [15:0]      rhalf;

    logic [31:0] mem [DEPTH_WORDS] = '{default: 32'h0};

    assign in_idle   = (state == IDLE);
    assign req_ready = in_idle && !rst;
    assign accept    = req_valid && req_ready;
    // With no wait cycles the accept edge is also the commit edge.
    assign commit    = (accept && (WAIT_CYCLES == 0)) || ((state == WAIT) && (cnt == 4'd1));
    assign rsp_valid = (state == RESP);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    if (WAIT_CYCLES == 0) begin
                        state_nxt = RESP;
                    end else begin
                        state_nxt = WAIT;
                        cnt_nxt   = 4'(WAIT_CYCLES);
                    end
                end
            end
            WAIT: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt == 4'd1) state_nxt = RESP;
            end
            RESP:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            lat_we     <= req_we;
            lat_addr   <= req_addr;
            lat_funct3 <= req_funct3;
            lat_wdata  <= req_wdata;
        end
    end

    // In IDLE the live request is the one being accepted; afterwards only the latched copy counts.
    assign cur_we     = in_idle ? req_we     : lat_we;
    assign cur_addr   = in_idle ? req_addr   : lat_addr;
    assign cur_funct3 = in_idle ? req_funct3 : lat_funct3;
    assign cur_wdata  = in_idle ? req_wdata  : lat_wdata;

    assign word_idx = cur_addr[IDX_W+1:2];
    assign lane     = cur_addr[1:0];

    always_comb begin
        if (cur_we)
            bad_funct3 = cur_funct3[2] || (cur_funct3[1:0] == 2'b11);
        else
            bad_funct3 = (cur_funct3 == 3'b011) || (cur_funct3 == 3'b110) || (cur_funct3 == 3'b111);
        misaligned   = ((cur_funct3[1:0] == 2'b01) && lane[0]) ||
                       ((cur_funct3[1:0] == 2'b10) && (lane != 2'b00));
        out_of_range = (cur_addr >> (IDX_W + 2)) != '0;
        acc_err      = bad_funct3 || misaligned || out_of_range;
    end

    always_comb begin
        be    = 4'b1111;
        wlane = cur_wdata;
        case (cur_funct3[1:0])
            2'b00: begin
                be    = 4'b0001 << lane;
                wlane = {4{cur_wdata[7:0]}};
            end
            2'b01: begin
                be    = lane[1] ? 4'b1100 : 4'b0011;
                wlane = {2{cur_wdata[15:0]}};
            end
            default: begin
                be    = 4'b1111;
                wlane = cur_wdata;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (commit && cur_we && !acc_err) begin
            for (int b = 0; b < 4; b++)
                if (be[b]) mem[word_idx][b*8 +: 8] <= wlane[b*8 +: 8];
        end
    end

    always_comb begin
        rword  = mem[word_idx];
        rshift = rword >> {lane, 3'b000};
        rhalf  = lane[1] ? rword[31:16] : rword[15:0];
        case (cur_funct3)
            3'b000:  load_val = {{24{rshift[7]}}, rshift[7:0]};
            3'b001:  load_val = {{16{rhalf[15]}}, rhalf};
            3'b010:  load_val = rword;
            3'b100:  load_val = {24'h0, rshift[7:0]};
            3'b101:  load_val = {16'h0, rhalf};
            default: load_val = 32'h0;
        endcase
        rdata_nxt = (cur_we || acc_err) ? 32'h0 : load_val;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_rdata <= 32'h0;
            rsp_err   <= 1'b0;
        end else if (commit) begin
            rsp_rdata <= rdata_nxt;
            rsp_err   <= acc_err;
        end
    end

endmodule

// File: tb/tb_mem_wait_ram.sv
// Bench for mem_wait_ram: directed plan steps, reset abort, throughput at two latencies,
// then random traffic against a byte-level reference memory.
module tb_mem_wait_ram;
    localparam int W = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid, req_valid_t, req_we;
    logic [31:0] req_addr, req_wdata;
    logic [2:0]  req_funct3;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic        rdy0, rv0, er0, rdy3, rv3, er3;
    logic [31:0] rd0, rd3;

    int checks = 0;
    int errors = 0;

    logic [31:0] ref_mem [1024];

    always #5 clk = ~clk;

    mem_wait_ram #(.ADDR_WIDTH(32), .DEPTH_WORDS(1024), .WAIT_CYCLES(W)) dut (
        .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err));

    mem_wait_ram #(.ADDR_WIDTH(32), .DEPTH_WORDS(1024), .WAIT_CYCLES(0)) u0 (
        .clk(clk), .rst(rst), .req_valid(req_valid_t), .req_ready(rdy0), .req_we(req_we),
        .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
        .rsp_valid(rv0), .rsp_rdata(rd0), .rsp_err(er0));

    mem_wait_ram #(.ADDR_WIDTH(32), .DEPTH_WORDS(1024), .WAIT_CYCLES(3)) u3 (
        .clk(clk), .rst(rst), .req_valid(req_valid_t), .req_ready(rdy3), .req_we(req_we),
        .req_addr(req_addr), .req_funct3(req_funct3), .req_wdata(req_wdata),
        .rsp_valid(rv3), .rsp_rdata(rd3), .rsp_err(er3));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: byte-addressed memory, size = 2**funct3[1:0] bytes, sign from funct3[2].
    function automatic void model(input logic we, input logic [31:0] a, input logic [2:0] f3,
                                  input logic [31:0] wd, output logic [31:0] rd, output logic e);
        int unsigned sz, w, off;
        logic [31:0] v;
        bit ok;
        sz = 1 << f3[1:0];
        ok = we ? (f3 <= 3'd2) : ((f3 <= 3'd2) || f3 == 3'd4 || f3 == 3'd5);
        e  = !ok || (a >= 32'd4096) || ((a % sz) != 0);
        rd = 32'h0;
        if (e) return;
        w   = a / 4;
        off = a % 4;
        if (we) begin
            for (int i = 0; i < int'(sz); i++) ref_mem[w][(off + i) * 8 +: 8] = wd[i * 8 +: 8];
        end else begin
            v = ref_mem[w] >> (off * 8);
            if (sz < 4) begin
                v = v & ((32'd1 << (sz * 8)) - 32'd1);
                if (!f3[2] && v >= (32'd1 << (sz * 8 - 1))) v = v - (32'd1 << (sz * 8));
            end
            rd = v;
        end
    endfunction

    task automatic txn(input string tag, input logic we, input logic [31:0] a, input logic [2:0] f3,
                       input logic [31:0] wd, output logic [31:0] rd, output logic er);
        logic [31:0] exp_rd;
        logic        exp_er;
        int          n;
        model(we, a, f3, wd, exp_rd, exp_er);
        @(negedge clk);
        req_valid = 1; req_we = we; req_addr = a; req_funct3 = f3; req_wdata = wd;
        n = 0;
        while (!req_ready && n < 20) begin @(negedge clk); n++; end
        @(posedge clk);
        #1;
        // Garbage while busy must be ignored, including a still-asserted valid.
        req_we = 1'($urandom); req_addr = $urandom; req_funct3 = 3'($urandom); req_wdata = $urandom;
        n = 0;
        do begin @(negedge clk); n++; end while (!rsp_valid && n < 20);
        req_valid = 0;
        chk({tag, ".latency"}, n, W + 1);
        chk({tag, ".ready_busy"}, {31'h0, req_ready}, 32'h0);
        chk({tag, ".rdata"}, rsp_rdata, exp_rd);
        chk({tag, ".err"}, {31'h0, rsp_err}, {31'h0, exp_er});
        rd = rsp_rdata;
        er = rsp_err;
        @(negedge clk);
        chk({tag, ".oneshot"}, {31'h0, rsp_valid}, 32'h0);
    endtask

    initial begin
        logic [31:0] rd;
        logic        er;
        logic        seen;
        int          acc0 [$];
        int          acc3 [$];
        for (int i = 0; i < 1024; i++) ref_mem[i] = 32'h0;
        rst = 1; req_valid = 0; req_valid_t = 0; req_we = 0; req_addr = 0; req_funct3 = 0; req_wdata = 0;

        repeat (3) @(negedge clk);
        chk("rst.ready", {31'h0, req_ready}, 32'h0);
        chk("rst.valid", {31'h0, rsp_valid}, 32'h0);
        chk("rst.rdata", rsp_rdata, 32'h0);
        chk("rst.err", {31'h0, rsp_err}, 32'h0);
        rst = 0;
        #1 chk("rst.ready_after", {31'h0, req_ready}, 32'h1);

        txn("sw10", 1, 32'h10, 3'd2, 32'hDEADBEEF, rd, er);
        txn("lw10", 0, 32'h10, 3'd2, 0, rd, er);  chk("lw10.const", rd, 32'hDEADBEEF);
        txn("sb13", 1, 32'h13, 3'd0, 32'h80, rd, er);
        txn("lb13", 0, 32'h13, 3'd0, 0, rd, er);  chk("lb13.const", rd, 32'hFFFFFF80);
        txn("lbu13", 0, 32'h13, 3'd4, 0, rd, er); chk("lbu13.const", rd, 32'h00000080);
        txn("lw10b", 0, 32'h10, 3'd2, 0, rd, er); chk("lw10b.const", rd, 32'h80ADBEEF);
        txn("sh12", 1, 32'h12, 3'd1, 32'h8001, rd, er);
        txn("lh12", 0, 32'h12, 3'd1, 0, rd, er);  chk("lh12.const", rd, 32'hFFFF8001);
        txn("lhu12", 0, 32'h12, 3'd5, 0, rd, er); chk("lhu12.const", rd, 32'h00008001);
        txn("lw10c", 0, 32'h10, 3'd2, 0, rd, er); chk("lw10c.const", rd, 32'h8001BEEF);
        txn("lh11", 0, 32'h11, 3'd1, 0, rd, er);  chk("lh11.err", {31'h0, er}, 32'h1);
        txn("sw12", 1, 32'h12, 3'd2, 32'h12345678, rd, er); chk("sw12.err", {31'h0, er}, 32'h1);
        txn("ld011", 0, 32'h10, 3'd3, 0, rd, er); chk("ld011.err", {31'h0, er}, 32'h1);
        txn("lw10d", 0, 32'h10, 3'd2, 0, rd, er); chk("lw10d.const", rd, 32'h8001BEEF);
        txn("lw1000", 0, 32'h1000, 3'd2, 0, rd, er); chk("lw1000.err", {31'h0, er}, 32'h1);
        txn("lwffc", 0, 32'hFFC, 3'd2, 0, rd, er);   chk("lwffc.err", {31'h0, er}, 32'h0);
        txn("lw10e", 0, 32'h10, 3'd2, 0, rd, er); chk("lw10e.const", rd, 32'h8001BEEF);

        // Reset pulse while a store sits in WAIT: no response, no write.
        @(negedge clk);
        req_valid = 1; req_we = 1; req_addr = 32'h10; req_funct3 = 3'd2; req_wdata = 32'hFFFFFFFF;
        @(posedge clk);
        #1 req_valid = 0;
        @(negedge clk);
        rst = 1;
        #1;
        chk("abort.ready", {31'h0, req_ready}, 32'h0);
        chk("abort.valid", {31'h0, rsp_valid}, 32'h0);
        chk("abort.rdata", rsp_rdata, 32'h0);
        @(negedge clk);
        rst = 0;
        seen = 0;
        repeat (6) begin @(negedge clk); if (rsp_valid) seen = 1; end
        chk("abort.no_rsp", {31'h0, seen}, 32'h0);
        txn("lw_after_abort", 0, 32'h10, 3'd2, 0, rd, er); chk("abort.lw_const", rd, 32'h8001BEEF);

        // Throughput with valid held high for 20 cycles.
        @(negedge clk);
        req_we = 0; req_addr = 32'h0; req_funct3 = 3'd2; req_valid_t = 1;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (c == 0) begin
                acc0.delete(); acc3.delete();
            end
            if (rdy0) acc0.push_back(c);
            if (rdy3) acc3.push_back(c);
        end
        @(posedge clk);
        #1 req_valid_t = 0;
        chk("tput0.count", acc0.size(), 10);
        chk("tput3.count", acc3.size(), 4);
        for (int i = 1; i < acc0.size(); i++) chk("tput0.gap", acc0[i] - acc0[i-1], 2);
        for (int i = 1; i < acc3.size(); i++) chk("tput3.gap", acc3[i] - acc3[i-1], 5);

        // Random traffic concentrated on a few words so loads hit earlier stores.
        for (int k = 0; k < 60; k++) begin
            logic [31:0] a;
            int unsigned r;
            r = $urandom_range(0, 9);
            if (r == 0)      a = 32'h1000 + $urandom_range(0, 32'hFFFF);
            else if (r == 1) a = 32'hFFC + $urandom_range(0, 3);
            else             a = $urandom_range(0, 63);
            txn("rand", 1'($urandom), a, 3'($urandom), $urandom, rd, er);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end
endmodule
